// File: rtl/shot_clock_countdown_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shot_clock_pkg
// Description : Shared types, load constants and BCD helpers for the
//               24-second shot clock.
//               - sc_state_t : IDLE / RUN / PAUSED / EXPIRED
//               - sc_value_t : four BCD digits SS.cc (sec_tens first)
//               - SC_LOAD24 / SC_LOAD14 : reload values 24.00 / 14.00
// Revision    : 1.0 - initial release
// ============================================================================
package shot_clock_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        SC_IDLE    = 2'd0,
        SC_RUN     = 2'd1,
        SC_PAUSED  = 2'd2,
        SC_EXPIRED = 2'd3
    } sc_state_t;

    typedef struct packed {
        bcd_t sec_tens;
        bcd_t sec_ones;
        bcd_t cs_tens;
        bcd_t cs_ones;
    } sc_value_t;

    localparam sc_value_t SC_LOAD24 = '{sec_tens: 4'd2, sec_ones: 4'd4, cs_tens: 4'd0, cs_ones: 4'd0};
    localparam sc_value_t SC_LOAD14 = '{sec_tens: 4'd1, sec_ones: 4'd4, cs_tens: 4'd0, cs_ones: 4'd0};
    localparam sc_value_t SC_ZERO   = '{sec_tens: 4'd0, sec_ones: 4'd0, cs_tens: 4'd0, cs_ones: 4'd0};
    localparam sc_value_t SC_ONE_CS = '{sec_tens: 4'd0, sec_ones: 4'd0, cs_tens: 4'd0, cs_ones: 4'd1};

    // True when the value is strictly below 14.00. Only the seconds digits
    // matter because 14.00 has zero centiseconds.
    function automatic logic sc_below_14(input sc_value_t v);
        return (v.sec_tens == 4'd0) ||
               ((v.sec_tens == 4'd1) && (v.sec_ones < 4'd4));
    endfunction

    // Subtract 00.01 with a BCD borrow cascade. Callers never pass 00.00.
    function automatic sc_value_t sc_decrement(input sc_value_t v);
        sc_value_t r;
        r = v;
        if (v.cs_ones != 4'd0) begin
            r.cs_ones = v.cs_ones - 4'd1;
        end else begin
            r.cs_ones = 4'd9;
            if (v.cs_tens != 4'd0) begin
                r.cs_tens = v.cs_tens - 4'd1;
            end else begin
                r.cs_tens = 4'd9;
                if (v.sec_ones != 4'd0) begin
                    r.sec_ones = v.sec_ones - 4'd1;
                end else begin
                    r.sec_ones = 4'd9;
                    r.sec_tens = v.sec_tens - 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shot_clock_countdown_if.sv
`default_nettype none
// ============================================================================
// Module      : shot_clock_countdown_if
// Description : Command / display bundle of the shot clock.
//               Inputs to the clock : tick_toggle, start, pause,
//                                     reload24, reload14
//               Outputs of the clock: sec_tens, sec_ones, cs_tens, cs_ones,
//                                     running, expired, buzzer
//               master = controller / display side, slave = shot clock.
// Revision    : 1.0 - initial release
// ============================================================================
interface shot_clock_countdown_if;
    import shot_clock_pkg::*;

    logic tick_toggle;
    logic start;
    logic pause;
    logic reload24;
    logic reload14;
    bcd_t sec_tens;
    bcd_t sec_ones;
    bcd_t cs_tens;
    bcd_t cs_ones;
    logic running;
    logic expired;
    logic buzzer;

    modport master (
        output tick_toggle, start, pause, reload24, reload14,
        input  sec_tens, sec_ones, cs_tens, cs_ones, running, expired, buzzer
    );

    modport slave (
        input  tick_toggle, start, pause, reload24, reload14,
        output sec_tens, sec_ones, cs_tens, cs_ones, running, expired, buzzer
    );
endinterface
`default_nettype wire

// File: rtl/shot_clock_countdown_edge.sv
`default_nettype none
// ============================================================================
// Module      : toggle_edge_detect
// Description : Synchronises the timebase toggle and emits a one-cycle
//               tick on every transition (rising or falling).
//               clk, reset      : system clock, async active-high reset
//               tick_toggle_i   : asynchronous timebase toggle
//               tick_o          : one-cycle pulse per toggle transition
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic tick_toggle_i,
    output logic      tick_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q[0] <= tick_toggle_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // History resets low, so a toggle already high at reset release is
    // reported as one tick.
    assign tick_o = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule
`default_nettype wire

// File: rtl/shot_clock_countdown.sv
`default_nettype none
// ============================================================================
// Module      : shot_clock_countdown
// Description : 24-second shot clock counting down in centiseconds (BCD)
//               from a 10 ms toggle timebase, with start/pause, 24/14 s
//               reloads, expiry flag and a timed buzzer.
//               clk, reset : system clock, async active-high reset
//               bus        : shot_clock_countdown_if.slave (commands in,
//                            BCD digits and status flags out)
// Revision    : 1.0 - initial release
// ============================================================================
module shot_clock_countdown
    import shot_clock_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int BUZZ_TICKS  = 100
) (
    input  wire logic              clk,
    input  wire logic              reset,
    shot_clock_countdown_if.slave  bus
);

    localparam logic [6:0] BUZZ_LOAD = 7'(BUZZ_TICKS);

    logic       tick;
    sc_state_t  state_q, state_d;
    sc_value_t  value_q, value_d;
    logic [6:0] buzz_cnt_q, buzz_cnt_d;
    logic       buzzer_q, buzzer_d;
    logic       running_q, expired_q;

    toggle_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge (
        .clk           (clk),
        .reset         (reset),
        .tick_toggle_i (bus.tick_toggle),
        .tick_o        (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SC_IDLE;
            value_q    <= SC_LOAD24;
            buzz_cnt_q <= 7'd0;
            buzzer_q   <= 1'b0;
            running_q  <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            buzz_cnt_q <= buzz_cnt_d;
            buzzer_q   <= buzzer_d;
            // Flags follow the next state so they change on the same edge.
            running_q  <= (state_d == SC_RUN);
            expired_q  <= (state_d == SC_EXPIRED);
        end
    end

    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        buzz_cnt_d = buzz_cnt_q;
        buzzer_d   = buzzer_q;

        if (bus.reload24 || (bus.reload14 && sc_below_14(value_q))) begin
            value_d = bus.reload24 ? SC_LOAD24 : SC_LOAD14;
            if (state_q == SC_EXPIRED) begin
                state_d    = SC_IDLE;
                buzzer_d   = 1'b0;
                buzz_cnt_d = 7'd0;
            end
        end else if (bus.reload14) begin
            // Ineffective 14 s reload still owns the cycle: nothing moves.
            value_d = value_q;
        end else begin
            case (state_q)
                SC_IDLE: begin
                    if (!bus.pause && bus.start) begin
                        state_d = SC_RUN;
                    end
                end
                SC_RUN: begin
                    if (bus.pause) begin
                        state_d = SC_PAUSED;
                    end else if (tick && (value_q != SC_ZERO)) begin
                        value_d = sc_decrement(value_q);
                        if (value_q == SC_ONE_CS) begin
                            state_d    = SC_EXPIRED;
                            buzzer_d   = 1'b1;
                            buzz_cnt_d = BUZZ_LOAD;
                        end
                    end
                end
                SC_PAUSED: begin
                    if (!bus.pause && bus.start) begin
                        state_d = SC_RUN;
                    end
                end
                SC_EXPIRED: begin
                    if (tick && (buzz_cnt_q != 7'd0)) begin
                        buzz_cnt_d = buzz_cnt_q - 7'd1;
                        if (buzz_cnt_q == 7'd1) begin
                            buzzer_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = SC_IDLE;
                end
            endcase
        end
    end

    assign bus.sec_tens = value_q.sec_tens;
    assign bus.sec_ones = value_q.sec_ones;
    assign bus.cs_tens  = value_q.cs_tens;
    assign bus.cs_ones  = value_q.cs_ones;
    assign bus.running  = running_q;
    assign bus.expired  = expired_q;
    assign bus.buzzer   = buzzer_q;

endmodule
`default_nettype wire

// File: tb/tb_shot_clock_countdown.sv
`default_nettype none
// ============================================================================
// Module      : tb_shot_clock_countdown
// Description : Self-checking bench for shot_clock_countdown. Expected
//               observations are pushed to a scoreboard queue as stimulus
//               is applied and popped when the outputs are sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shot_clock_countdown;

    typedef struct packed {
        logic [15:0] v;
        logic        run;
        logic        exp;
        logic        buz;
    } obs_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    obs_t sb[$];
    obs_t e_v;
    obs_t g_v;

    shot_clock_countdown_if bus ();

    shot_clock_countdown #(
        .SYNC_STAGES (2),
        .BUZZ_TICKS  (100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    // Expected observation built from an integer centisecond count.
    function automatic obs_t mk(input int cs, input bit r, input bit x, input bit b);
        obs_t o;
        o.v   = {4'(cs / 1000), 4'((cs / 100) % 10), 4'((cs / 10) % 10), 4'(cs % 10)};
        o.run = r;
        o.exp = x;
        o.buz = b;
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.v   = {bus.sec_tens, bus.sec_ones, bus.cs_tens, bus.cs_ones};
        o.run = bus.running;
        o.exp = bus.expired;
        o.buz = bus.buzzer;
        return o;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset           = 1'b1;
        bus.tick_toggle = 1'b0;
        bus.start       = 1'b0;
        bus.pause       = 1'b0;
        bus.reload24    = 1'b0;
        bus.reload14    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // One-cycle command; outputs are sampled at the negedge after it lands.
    task automatic cmd(input bit s, input bit p, input bit r24, input bit r14);
        @(negedge clk);
        bus.start    = s;
        bus.pause    = p;
        bus.reload24 = r24;
        bus.reload14 = r14;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.pause    = 1'b0;
        bus.reload24 = 1'b0;
        bus.reload14 = 1'b0;
    endtask

    // One timebase transition, waited out past sync + update latency.
    task automatic apply_edge();
        @(negedge clk);
        bus.tick_toggle = ~bus.tick_toggle;
        repeat (4) @(negedge clk);
    endtask

    task automatic run_edges(input int n);
        for (int i = 0; i < n; i++) apply_edge();
    endtask

    task automatic test_reset();
        do_reset();
        sb.push_back(mk(2400, 0, 0, 0));
        e_v = sb.pop_front(); g_v = observe(); total++;
        if (g_v !== e_v) begin bad++; $display("FAIL reset_state: got %h want %h", g_v, e_v); end
        apply_edge();
        sb.push_back(mk(2400, 0, 0, 0));
        e_v = sb.pop_front(); g_v = observe(); total++;
        if (g_v !== e_v) begin bad++; $display("FAIL idle_ignores_tick: got %h want %h", g_v, e_v); end
    endtask

    task automatic test_full_countdown();
        do_reset();
        cmd(1, 0, 0, 0);
        sb.push_back(mk(2400, 1, 0, 0));
        e_v = sb.pop_front(); g_v = observe(); total++;
        if (g_v !== e_v) begin bad++; $display("FAIL start: got %h want %h", g_v, e_v); end
        for (int i = 1; i <= 2400; i++) begin
            apply_edge();
            sb.push_back(mk(2400 - i, i < 2400, i == 2400, i == 2400));
            e_v = sb.pop_front(); g_v = observe(); total++;
            if (g_v !== e_v) begin bad++; $display("FAIL countdown tick %0d: got %h want %h", i, g_v, e_v); end
        end
        for (int k = 1; k <= 102; k++) begin
            apply_edge();
            sb.push_back(mk(0, 0, 1, k < 100));
            e_v = sb.pop_front(); g_v = observe(); total++;
            if (g_v !== e_v) begin bad++; $display("FAIL buzzer tick %0d: got %h want %h", k, g_v, e_v); end
        end
        cmd(1, 1, 0, 0);
        cmd(1, 0, 0, 0);
        sb.push_back(mk(0, 0, 1, 0));
        e_v = sb.pop_front(); g_v = observe(); total++;
        if (g_v !== e_v) begin bad++; $display("FAIL expired_ignores_cmds: got %h want %h", g_v, e_v); end
    endtask

    task automatic test_pause();
        do_reset();
        cmd(1, 0, 0, 0);
        run_edges(50);
        sb.push_back(mk(2350, 1, 0, 0));
        e_v = sb.pop_front(); g_v = observe(); total++;
        if (g_v !== e_v) begin bad++; $display("FAIL pause_pre: got %h want %h", g_v, e_v); end
        cmd(0, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            apply_edge();
            sb.push_back(mk(2350, 0, 0, 0));
            e_v = sb.pop_front(); g_v = observe(); total++;
            if (g_v !== e_v) begin bad++; $display("FAIL paused_hold %0d: got %h want %h", i, g_v, e_v); end
        end
        cmd(1, 0, 0, 0);
        apply_edge();
        sb.push_back(mk(2349, 1, 0, 0));
        e_v = sb.pop_front(); g_v = observe(); total++;
        if (g_v !== e_v) begin bad++; $display("FAIL resume: got %h want %h", g_v, e_v); end
    endtask

    task automatic test_borrow();
        do_reset();
        cmd(1, 0, 0, 0);
        run_edges(400);
        apply_edge();
        sb.push_back(mk(1999, 1, 0, 0));
        e_v = sb.pop_front(); g_v = observe(); total++;
        if (g_v !== e_v) begin bad++; $display("FAIL borrow_20_00: got %h want %h", g_v, e_v); end
        run_edges(999);
        apply_edge();
        sb.push_back(mk(999, 1, 0, 0));
        e_v = sb.pop_front(); g_v = observe(); total++;
        if (g_v !== e_v) begin bad++; $display("FAIL borrow_10_00: got %h want %h", g_v, e_v); end
    endtask

    task automatic test_reload14();
        do_reset();
        cmd(1, 0, 0, 0);
        run_edges(870);
        cmd(0, 0, 0, 1);
        sb.push_back(mk(1530, 1, 0, 0));
        e_v = sb.pop_front(); g_v = observe(); total++;
        if (g_v !== e_v) begin bad++; $display("FAIL reload14_above: got %h want %h", g_v, e_v); end
        run_edges(710);
        cmd(0, 0, 0, 1);
        sb.push_back(mk(1400, 1, 0, 0));
        e_v = sb.pop_front(); g_v = observe(); total++;
        if (g_v !== e_v) begin bad++; $display("FAIL reload14_below: got %h want %h", g_v, e_v); end
        run_edges(1405);
        sb.push_back(mk(0, 0, 1, 1));
        e_v = sb.pop_front(); g_v = observe(); total++;
        if (g_v !== e_v) begin bad++; $display("FAIL reexpire: got %h want %h", g_v, e_v); end
        cmd(0, 0, 0, 1);
        sb.push_back(mk(1400, 0, 0, 0));
        e_v = sb.pop_front(); g_v = observe(); total++;
        if (g_v !== e_v) begin bad++; $display("FAIL reload14_expired: got %h want %h", g_v, e_v); end
        apply_edge();
        sb.push_back(mk(1400, 0, 0, 0));
        e_v = sb.pop_front(); g_v = observe(); total++;
        if (g_v !== e_v) begin bad++; $display("FAIL reload14_idle_after: got %h want %h", g_v, e_v); end
    endtask

    task automatic test_reload24_with_tick();
        do_reset();
        cmd(1, 0, 0, 0);
        run_edges(1400);
        sb.push_back(mk(1000, 1, 0, 0));
        e_v = sb.pop_front(); g_v = observe(); total++;
        if (g_v !== e_v) begin bad++; $display("FAIL r24_pre: got %h want %h", g_v, e_v); end
        @(negedge clk);
        bus.tick_toggle = ~bus.tick_toggle;
        @(negedge clk);
        @(negedge clk);
        bus.reload24 = 1'b1;
        @(negedge clk);
        bus.reload24 = 1'b0;
        sb.push_back(mk(2400, 1, 0, 0));
        e_v = sb.pop_front(); g_v = observe(); total++;
        if (g_v !== e_v) begin bad++; $display("FAIL r24_with_tick: got %h want %h", g_v, e_v); end
        repeat (4) @(negedge clk);
        sb.push_back(mk(2400, 1, 0, 0));
        e_v = sb.pop_front(); g_v = observe(); total++;
        if (g_v !== e_v) begin bad++; $display("FAIL r24_tick_consumed: got %h want %h", g_v, e_v); end
        apply_edge();
        sb.push_back(mk(2399, 1, 0, 0));
        e_v = sb.pop_front(); g_v = observe(); total++;
        if (g_v !== e_v) begin bad++; $display("FAIL r24_continue: got %h want %h", g_v, e_v); end
    endtask

    task automatic test_start_pause_idle();
        do_reset();
        cmd(1, 1, 0, 0);
        sb.push_back(mk(2400, 0, 0, 0));
        e_v = sb.pop_front(); g_v = observe(); total++;
        if (g_v !== e_v) begin bad++; $display("FAIL start_pause_idle: got %h want %h", g_v, e_v); end
        apply_edge();
        sb.push_back(mk(2400, 0, 0, 0));
        e_v = sb.pop_front(); g_v = observe(); total++;
        if (g_v !== e_v) begin bad++; $display("FAIL start_pause_no_count: got %h want %h", g_v, e_v); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        cmd(1, 0, 0, 0);
        run_edges(31);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        sb.push_back(mk(2400, 0, 0, 0));
        e_v = sb.pop_front(); g_v = observe(); total++;
        if (g_v !== e_v) begin bad++; $display("FAIL async_reset: got %h want %h", g_v, e_v); end
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        cmd(1, 0, 0, 0);
        apply_edge();
        sb.push_back(mk(2399, 1, 0, 0));
        e_v = sb.pop_front(); g_v = observe(); total++;
        if (g_v !== e_v) begin bad++; $display("FAIL post_reset_edge: got %h want %h", g_v, e_v); end
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        reset           = 1'b1;
        bus.tick_toggle = 1'b0;
        bus.start       = 1'b0;
        bus.pause       = 1'b0;
        bus.reload24    = 1'b0;
        bus.reload14    = 1'b0;
        test_reset();
        test_full_countdown();
        test_pause();
        test_borrow();
        test_reload14();
        test_reload24_with_tick();
        test_start_pause_idle();
        test_reset_midrun();
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
